// File: rtl/clk_div_gen.sv
// Programmable divided-clock generator: run-time period/high-time over valid/ready,
// applied only on period boundaries, with registered rise/fall strobes.
module clk_div_gen #(
    parameter int WIDTH      = 8,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             div_out,
    output logic             rise,
    output logic             fall,
    output logic [WIDTH-1:0] active_period
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_p, act_h;
    logic [WIDTH-1:0] pend_p, pend_h;
    logic             pend_full;

    logic             xfer;
    logic             wrap;
    logic             apply;
    logic             div_next;
    logic [WIDTH-1:0] cfg_period_cl;

    assign cfg_ready     = ~pend_full;
    assign xfer          = cfg_valid & ~pend_full;
    assign cfg_period_cl = (cfg_period < WIDTH'(2)) ? WIDTH'(2) : cfg_period;
    // >= rather than == keeps the counter safe if the period ever shrinks under it.
    assign wrap          = (state == ST_RUN) && (cnt >= act_p - WIDTH'(1));
    assign apply         = pend_full && ((state == ST_IDLE) || wrap);
    assign div_next      = (state == ST_RUN) && (cnt < act_h);
    assign active_period = act_p;

    // NOTE: every register here is updated with <= so all reads see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            div_out   <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            act_p     <= WIDTH'(DEF_PERIOD);
            act_h     <= WIDTH'(DEF_HIGH);
            pend_p    <= '0;
            pend_h    <= '0;
            pend_full <= 1'b0;
        end else begin
            // div_out lags the counter by one cycle; strobes are aligned with div_out.
            div_out <= div_next;
            rise    <= div_next & ~div_out;
            fall    <= ~div_next & div_out;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (en) state <= ST_RUN;
                end
                default: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (wrap) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
            endcase

            // A transfer needs an empty slot, so apply and xfer never coincide.
            if (apply) begin
                act_p     <= pend_p;
                act_h     <= pend_h;
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend_p    <= cfg_period_cl;
                pend_h    <= cfg_high;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: cycle model feeds a scoreboard queue,
// plus directed waveform counts for each scenario.
module tb_clk_div_gen;

    logic       clk = 1'b0;
    logic       rst, en, cfg_valid;
    logic [7:0] cfg_period, cfg_high;
    logic       cfg_ready, div_out, rise, fall;
    logic [7:0] active_period;

    clk_div_gen dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_high      (cfg_high),
        .div_out       (div_out),
        .rise          (rise),
        .fall          (fall),
        .active_period (active_period)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       div;
        logic       rise;
        logic       fall;
        logic [7:0] ap;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit m_run, m_pf, m_div, m_rise, m_fall;
    int m_cnt, m_p, m_h, m_pp, m_ph;
    int c_high, c_rise, c_fall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model, evaluated on the inputs the DUT samples at this edge.
    task automatic model_step();
        bit xfer, nd, apply, wrap;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_div = 0; m_rise = 0; m_fall = 0;
            m_p = 10; m_h = 5; m_pf = 0;
            return;
        end
        xfer   = cfg_valid && !m_pf;
        nd     = m_run && (m_cnt < m_h);
        m_rise = nd && !m_div;
        m_fall = !nd && m_div;
        m_div  = nd;
        if (!m_run) begin
            apply = m_pf;
            m_cnt = 0;
        end else begin
            wrap  = (m_cnt == m_p - 1);
            apply = wrap && m_pf;
            m_cnt = (wrap || !en) ? 0 : m_cnt + 1;
        end
        m_run = en;
        if (apply) begin
            m_p = m_pp; m_h = m_ph; m_pf = 0;
        end else if (xfer) begin
            m_pp = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
            m_ph = int'(cfg_high);
            m_pf = 1;
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_step();
        e.div = m_div; e.rise = m_rise; e.fall = m_fall;
        e.ap = 8'(m_p); e.ready = !m_pf;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("sb_div_out", div_out, e.div);
            check("sb_rise", rise, e.rise);
            check("sb_fall", fall, e.fall);
            check("sb_active_period", active_period, e.ap);
            check("sb_cfg_ready", cfg_ready, e.ready);
        end
        c_high += int'(div_out);
        c_rise += int'(rise);
        c_fall += int'(fall);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        c_high = 0; c_rise = 0; c_fall = 0;
    endtask

    task automatic send_cfg(input int p, input int h);
        for (int i = 0; i < 40 && !cfg_ready; i++) step();
        check("cfg_ready_wait", cfg_ready, 1);
        cfg_valid  = 1'b1;
        cfg_period = 8'(p);
        cfg_high   = 8'(h);
        step();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
        @(negedge clk);
        run(2);
        check("rst_div_out", div_out, 0);
        check("rst_active_period", active_period, 10);
        check("rst_cfg_ready", cfg_ready, 1);

        // Defaults: 5 high / 5 low.
        rst = 1'b0; en = 1'b1;
        step();
        clear_counts();
        run(20);
        check("def_high", c_high, 10);
        check("def_rise", c_rise, 2);
        check("def_fall", c_fall, 2);

        // P=10,H=8 transferred at cnt=3; slot stays full until the boundary.
        for (int i = 0; i < 30 && m_cnt != 3; i++) step();
        check("wait_cnt3", m_cnt, 3);
        send_cfg(10, 8);
        check("ready_low_after_xfer", cfg_ready, 0);
        run(20);
        clear_counts();
        run(20);
        check("h8_high", c_high, 16);
        check("h8_rise", c_rise, 2);

        // H=0 constant low, then H=12 >= P constant high with one rise.
        send_cfg(10, 0);
        run(25);
        clear_counts();
        run(20);
        check("h0_high", c_high, 0);
        check("h0_rise", c_rise, 0);
        check("h0_fall", c_fall, 0);
        clear_counts();
        send_cfg(10, 12);
        run(25);
        check("h12_rise", c_rise, 1);
        check("h12_fall", c_fall, 0);
        clear_counts();
        run(20);
        check("h12_high", c_high, 20);

        // P=1 clamps to 2; H=1 toggles every cycle.
        send_cfg(1, 1);
        run(25);
        check("p1_active_period", active_period, 2);
        clear_counts();
        run(20);
        check("p2_high", c_high, 10);
        check("p2_rise", c_rise, 10);
        check("p2_fall", c_fall, 10);

        // Drop en during the high phase, then restart.
        send_cfg(10, 5);
        run(25);
        for (int i = 0; i < 20 && !div_out; i++) step();
        check("wait_high", div_out, 1);
        en = 1'b0;
        clear_counts();
        run(2);
        check("en_drop_div_out", div_out, 0);
        check("en_drop_fall", c_fall, 1);
        clear_counts();
        run(5);
        check("idle_high", c_high, 0);
        en = 1'b1;
        clear_counts();
        run(3);
        check("restart_rise", c_rise, 1);
        check("restart_div_out", div_out, 1);

        // Reset mid-period with a pending config and a transfer in the reset cycle.
        for (int i = 0; i < 30 && m_cnt != 1; i++) step();
        check("wait_cnt1", m_cnt, 1);
        send_cfg(4, 1);
        check("pending_ready", cfg_ready, 0);
        rst = 1'b1; cfg_valid = 1'b1; cfg_period = 8'd3; cfg_high = 8'd2;
        step();
        rst = 1'b0; cfg_valid = 1'b0;
        check("mrst_div_out", div_out, 0);
        check("mrst_rise", rise, 0);
        check("mrst_fall", fall, 0);
        check("mrst_cfg_ready", cfg_ready, 1);
        check("mrst_active_period", active_period, 10);
        step();
        clear_counts();
        run(20);
        check("post_rst_high", c_high, 10);
        check("post_rst_rise", c_rise, 2);
        check("post_rst_active_period", active_period, 10);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
